// File: rtl/vcu_msg_pkg.sv
// rtl/vcu_msg_pkg.sv - shared select codes and credit FSM state for the message receive endpoint
package vcu_msg_pkg;

    localparam logic [3:0] MSG_SEL_STATUS  = 4'h3;
    localparam logic [3:0] MSG_SEL_POP     = 4'h5;
    localparam logic [3:0] MSG_SEL_COUNT   = 4'h6;
    localparam logic [3:0] MSG_SEL_DATA    = 4'h9;
    localparam logic [3:0] MSG_SEL_OVF_CLR = 4'hA;

    typedef enum logic {
        CR_ACCUM   = 1'b0,
        CR_RELEASE = 1'b1
    } cr_state_t;

endpackage

// File: rtl/vcu_msg_rx_fifo.sv
// rtl/vcu_msg_rx_fifo.sv - message FIFO: storage, natural-wrap pointers, occupancy count, full/empty
module vcu_msg_rx_fifo
    import vcu_msg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_push_ok,
    output logic                       o_pop_ok,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_pop_ok  = i_pop && !o_empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign o_push_ok = i_push && (!o_full || o_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (o_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (o_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (o_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({o_push_ok, o_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vcu_msg_rx.sv
// rtl/vcu_msg_rx.sv - credit-based message receive endpoint with VCU register access
// Optional batched credit release when MSG_RX_CREDIT_BATCH_EN is defined.
module vcu_msg_rx
    import vcu_msg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int BATCH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] msg_data_i,
    input  logic             msg_we_i,
    output logic             credit_ret_o,
    input  logic [31:0]      vcu_reg_control,
    input  logic             vcu_reg_control_we,
    input  logic [31:0]      vcu_reg_wdata,
    input  logic             vcu_reg_wdata_we,
    output logic [31:0]      vcu_reg_rdata,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_BATCH = CW'(BATCH);

    logic [3:0]       w_sel;
    logic             w_pop_req;
    logic             w_ovf_clr;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_ovf_evt;
    logic [WIDTH-1:0] w_head;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             r_overflow;
    logic             w_unused;

    assign w_sel     = vcu_reg_control[3:0];
    assign w_pop_req = vcu_reg_control_we && (w_sel == MSG_SEL_POP);
    assign w_ovf_clr = vcu_reg_wdata_we && (w_sel == MSG_SEL_OVF_CLR);
    assign w_ovf_evt = msg_we_i && !w_push_ok;
    assign w_unused  = ^{vcu_reg_control[31:4], vcu_reg_wdata, LP_BATCH};

    vcu_msg_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (msg_we_i),
        .i_pop     (w_pop_req),
        .i_data    (msg_data_i),
        .o_push_ok (w_push_ok),
        .o_pop_ok  (w_pop_ok),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign empty_o    = w_empty;
    assign full_o     = w_full;
    assign overflow_o = r_overflow;

    // An overflow in the same cycle as a clear wins, so no drop goes unreported.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    always_comb begin
        vcu_reg_rdata = 32'h0;
        case (w_sel)
            MSG_SEL_STATUS: vcu_reg_rdata = {29'h0, r_overflow, w_full, ~w_empty};
            MSG_SEL_COUNT:  vcu_reg_rdata = 32'(w_count);
            MSG_SEL_DATA:   vcu_reg_rdata = w_empty ? 32'h0 : 32'(w_head);
            default:        vcu_reg_rdata = 32'h0;
        endcase
    end

`ifdef MSG_RX_CREDIT_BATCH_EN
    cr_state_t     r_state;
    cr_state_t     w_state_nxt;
    logic [CW-1:0] r_pending;
    logic [CW-1:0] w_pending_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CR_ACCUM;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Draining early on an empty FIFO keeps the producer from starving below BATCH.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending + CW'(w_pop_ok);
        case (r_state)
            CR_ACCUM: begin
                if ((r_pending >= LP_BATCH) || ((r_pending != '0) && w_empty)) begin
                    w_state_nxt = CR_RELEASE;
                end
            end
            CR_RELEASE: begin
                w_pending_nxt = r_pending - 1'b1 + CW'(w_pop_ok);
                if (w_pending_nxt == '0) begin
                    w_state_nxt = CR_ACCUM;
                end
            end
            default: w_state_nxt = CR_ACCUM;
        endcase
    end

    always_comb begin
        credit_ret_o = (r_state == CR_RELEASE);
    end
`else
    logic r_credit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop_ok;
        end
    end

    assign credit_ret_o = r_credit;
`endif

endmodule
